// File: rtl/cnt_disp_pkg.sv
// Shared constants for the signed-count display: segment patterns, internal digit codes and
// the default refresh divider.
package cnt_disp_pkg;

  localparam int unsigned REFRESH_DIV_DEF = 1000;

  // Internal digit codes beyond 0..9
  localparam logic [3:0] CODE_MINUS = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Decimal wrap counter step, 9 rolls over to 0
  function automatic logic [3:0] wrap_inc(input logic [3:0] v);
    return (v == 4'd9) ? 4'd0 : v + 4'd1;
  endfunction

endpackage

// File: rtl/cnt_disp_seg7_enc.sv
// Combinational decoder from a 4-bit internal digit code to an active-low 7-segment pattern.
module seg7_enc
  import cnt_disp_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  // Codes 11..14 are unused and render blank like CODE_BLANK
  always_comb begin
    seg_o = SEG_BLANK;
    unique case (code_i)
      4'd0:       seg_o = SEG_0;
      4'd1:       seg_o = SEG_1;
      4'd2:       seg_o = SEG_2;
      4'd3:       seg_o = SEG_3;
      4'd4:       seg_o = SEG_4;
      4'd5:       seg_o = SEG_5;
      4'd6:       seg_o = SEG_6;
      4'd7:       seg_o = SEG_7;
      4'd8:       seg_o = SEG_8;
      4'd9:       seg_o = SEG_9;
      CODE_MINUS: seg_o = SEG_MINUS;
      default:    seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/cnt_disp.sv
// Four-digit multiplexed display of a signed 5-bit sample: sign, tens, ones, and a decimal
// counter of +7 -> 0 wraps seen in the captured sample stream.
module cnt_disp
  import cnt_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] in_num,
  input  logic       in_vld,
  input  logic       hold,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam logic [15:0] PRESC_MAX = 16'(REFRESH_DIV - 1);

  logic        cap, cap_q;
  logic [4:0]  samp_q, prev_q;
  logic [3:0]  wrap_q, wrap_cur;
  logic        wrap_evt;
  logic [15:0] presc_q, presc_d;
  logic [1:0]  idx_q, idx_d;
  logic [4:0]  mag;
  logic        tens;
  logic [3:0]  ones;
  logic [3:0]  dig_code;
  logic [6:0]  seg_d, seg_q;
  logic [3:0]  an_d, an_q;
  logic        dp_d, dp_q;

  assign cap = in_vld & ~hold;

  // The wrap is resolved the cycle after the capture from prev/samp; wrap_cur is the
  // architectural count, so the display sees the increment with no extra delay.
  assign wrap_evt = cap_q && (prev_q == 5'd7) && (samp_q == 5'd0);
  assign wrap_cur = wrap_evt ? wrap_inc(wrap_q) : wrap_q;

  // Sample history and wrap counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q <= '0;
      prev_q <= '0;
      cap_q  <= 1'b0;
      wrap_q <= '0;
    end else begin
      cap_q  <= cap;
      wrap_q <= wrap_cur;
      if (cap) begin
        samp_q <= in_num;
        prev_q <= samp_q;
      end
    end
  end

  // Prescaler and digit index next state; index steps 3->2->1->0->3
  always_comb begin
    presc_d = presc_q + 16'd1;
    idx_d   = idx_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      idx_d   = idx_q - 2'd1;
    end
  end

  // Scan state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= 2'd3;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  // Magnitude and decimal split; -16 yields 16 in the 5-bit unsigned result
  always_comb begin
    mag  = samp_q[4] ? (~samp_q + 5'd1) : samp_q;
    tens = (mag >= 5'd10);
    ones = tens ? 4'(mag - 5'd10) : mag[3:0];
  end

  // Digit content for the currently selected position
  always_comb begin
    dig_code = CODE_BLANK;
    unique case (idx_q)
      2'd3: dig_code = samp_q[4] ? CODE_MINUS : CODE_BLANK;
      2'd2: dig_code = tens ? 4'd1 : CODE_BLANK;
      2'd1: dig_code = ones;
      2'd0: dig_code = wrap_cur;
      default: dig_code = CODE_BLANK;
    endcase
  end

  seg7_enc u_seg7_enc (
    .code_i (dig_code),
    .seg_o  (seg_d)
  );

  assign an_d = ~(4'b0001 << idx_q);
  assign dp_d = ~((idx_q == 2'd0) && hold);

  // Registered display drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_BLANK;
      an_q  <= 4'b1111;
      dp_q  <= 1'b1;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
      dp_q  <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule

// File: doc/cnt_disp.md
CNT_DISP -- requirements
Module: cnt_disp

Interface
REQ-001 Parameter REFRESH_DIV, default 1000, clock cycles each digit stays lit; legal range 2..65535.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_num  input  5  signed two's-complement sample from the upstream signed counter, range -16..+15.
REQ-005 in_vld  input  1  sample strobe; in_num is valid in any cycle with in_vld=1.
REQ-006 hold  input  1  freeze; when 1, new samples are ignored and scanning continues.
REQ-007 seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
REQ-008 an  output  4  digit enables, active-low, one-hot-low; an[3] is leftmost.
REQ-009 dp  output  1  decimal point, active-low.

Function
REQ-010 The block SHALL latch in_num into register samp on every edge where in_vld=1 and hold=0; no other event updates samp.
REQ-011 The block SHALL keep prev, the value of samp before the latest capture, updated on the same edge as samp.
REQ-012 Magnitude SHALL be computed as a 5-bit unsigned |samp| in the range 0..16; -16 SHALL give 16 with no overflow.
REQ-013 Tens digit SHALL be 1 when the magnitude is 10 or more, else 0; ones digit SHALL be the magnitude minus 10*tens.
REQ-014 Register wrap_cnt (0..9) SHALL increment on a capture where prev==+7 and the new in_num==0, wrapping 9->0; all other captures leave it unchanged.
REQ-015 Digit content: an[3] shows '-' if samp<0, else blank; an[2] shows the tens digit, blanked when 0; an[1] shows the ones digit, never blanked; an[0] shows wrap_cnt.
REQ-016 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; on each wrap, the 2-bit digit index SHALL advance 3->2->1->0->3.
REQ-017 seg, an and dp SHALL be registered, reflecting the index and samp/wrap_cnt values of the previous cycle (1-cycle latency).
REQ-018 Only the an bit selected by the index SHALL be low; an SHALL never have more than one bit low.
REQ-019 dp SHALL be 0 only while index=0 and hold=1; otherwise dp SHALL be 1.
REQ-020 Segment codes SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, '-'=0111111, blank=1111111.
REQ-021 A capture with hold falling in the same cycle as in_vld=1 SHALL be taken, because hold is sampled at the same edge.
REQ-022 Consecutive captures of 7 followed by 0 separated by non-capture cycles SHALL still count as a wrap, since prev tracks captures, not cycles.

Reset
REQ-023 While rst_n=0: samp=0, prev=0, wrap_cnt=0, prescaler=0, index=3, seg=1111111, an=1111, dp=1.
REQ-024 An assertion of rst_n mid-scan or mid-sample SHALL clear all state immediately, with no pending capture retained.
REQ-025 On the first edge after release, the block SHALL drive index 3 (blank sign for samp=0).

Structure
REQ-026 Package cnt_disp_pkg SHALL hold the segment code constants, the '-' and blank internal codes (10 and 15), and the REFRESH_DIV default.
REQ-027 One sub-module seg7_enc SHALL map a 4-bit internal code to the 7-bit active-low segment pattern, combinationally.
REQ-028 RTL SHALL be synthesizable and contain no latches.

Verification (REFRESH_DIV=4)
REQ-029 Release reset, no input: an sequence 0111,1011,1101,1110 each for 4 cycles; segs blank, blank, 0, 0.
REQ-030 Capture -10: sign digit '-' (0111111), tens 1 (1111001), ones 0 (1000000).
REQ-031 Capture -16: magnitude 16, digits '-', 1, 6 (0000010).
REQ-032 Capture 5,6,7,0 twice, then 7,0 once more: wrap_cnt=3, digit 0 shows 0110000.
REQ-033 hold=1, then in_vld with 3: display unchanged and dp=0 during index 0; after hold=0 and capture 3, ones digit shows 0110000.
REQ-034 Assert rst_n=0 mid-digit after wrap_cnt=2: all outputs blank immediately; after release, wrap_cnt digit shows 0.
